// File: rtl/reverse_msg_sequencer_pkg.sv
// Shared types and constants for the reverse message sequencer.
package reverse_msg_sequencer_pkg;
  localparam int CHAR_W        = 8;
  localparam int MSG_CHARS     = 8;
  localparam int ROM_LAST_ADDR = 9;
  localparam int ADDR_W        = 4;
  localparam logic [CHAR_W-1:0] ASCII_LF = 8'h0A;
  localparam logic [CHAR_W-1:0] ASCII_CR = 8'h0D;

  typedef enum logic [2:0] {
    COLLECT,
    LOAD,
    READ,
    SEND,
    WAIT
  } state_t;
endpackage

// File: rtl/reverse_msg_sequencer_if.sv
// Bus bundle between the sequencer and its UART RX, message ROM and UART TX.
interface reverse_msg_sequencer_if
  import reverse_msg_sequencer_pkg::*;
#(
  parameter int MSG_CHARS = reverse_msg_sequencer_pkg::MSG_CHARS
);
  logic [CHAR_W-1:0]           rx_data;
  logic                        new_rx_data;
  logic [CHAR_W*MSG_CHARS-1:0] bits_out;
  logic                        bits_valid;
  logic [ADDR_W-1:0]           addr;
  logic [CHAR_W-1:0]           rom_data;
  logic [CHAR_W-1:0]           tx_data;
  logic                        new_tx_data;
  logic                        tx_busy;

  modport master (
    input  rx_data, new_rx_data, rom_data, tx_busy,
    output bits_out, bits_valid, addr, tx_data, new_tx_data
  );

  modport slave (
    output rx_data, new_rx_data, rom_data, tx_busy,
    input  bits_out, bits_valid, addr, tx_data, new_tx_data
  );
endinterface

// File: rtl/reverse_msg_sequencer_byte_shift_packer.sv
// Shift-in byte register with char counter; new bytes enter at the top so the
// first byte of a message ends up in the lowest byte lane.
module reverse_msg_sequencer_byte_shift_packer
  import reverse_msg_sequencer_pkg::*;
#(
  parameter int MSG_CHARS = reverse_msg_sequencer_pkg::MSG_CHARS
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        shift_en,
  input  logic [CHAR_W-1:0]           din,
  output logic [CHAR_W*MSG_CHARS-1:0] bits_out,
  output logic                        bits_valid,
  output logic                        last_char
);
  localparam int W     = CHAR_W * MSG_CHARS;
  localparam int CNT_W = (MSG_CHARS > 1) ? $clog2(MSG_CHARS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MSG_CHARS - 1);

  logic [W-1:0]     bits_q, bits_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             valid_q, valid_d;

  assign last_char  = shift_en && (cnt_q == CNT_LAST);
  assign bits_out   = bits_q;
  assign bits_valid = valid_q;

  always_comb begin
    bits_d  = bits_q;
    cnt_d   = cnt_q;
    valid_d = 1'b0;
    if (shift_en) begin
      bits_d  = {din, bits_q[W-1:CHAR_W]};
      cnt_d   = last_char ? '0 : cnt_q + 1'b1;
      valid_d = last_char;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bits_q  <= '0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      bits_q  <= bits_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
    end
  end
endmodule

// File: rtl/reverse_msg_sequencer.sv
// Collects a message from UART RX, then walks the message ROM and prints it.
// Optional RX_ECHO_EN: echo each received byte to TX while collecting.
module reverse_msg_sequencer
  import reverse_msg_sequencer_pkg::*;
#(
  parameter int MSG_CHARS = reverse_msg_sequencer_pkg::MSG_CHARS,
  parameter int LAST_ADDR = reverse_msg_sequencer_pkg::ROM_LAST_ADDR
) (
  input logic                     clk,
  input logic                     rst,
  reverse_msg_sequencer_if.master bus
);
  localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(LAST_ADDR);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [CHAR_W-1:0] tx_data_q, tx_data_d;
  logic              new_tx_q, new_tx_d;
  logic              wait_first_q, wait_first_d;
  logic              shift_en, last_char;

  // Bytes outside COLLECT never reach the packer, which keeps bits_out frozen
  // for the whole print.
  assign shift_en = (state_q == COLLECT) && bus.new_rx_data;

  reverse_msg_sequencer_byte_shift_packer #(.MSG_CHARS(MSG_CHARS)) u_packer (
    .clk       (clk),
    .rst       (rst),
    .shift_en  (shift_en),
    .din       (bus.rx_data),
    .bits_out  (bus.bits_out),
    .bits_valid(bus.bits_valid),
    .last_char (last_char)
  );

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    tx_data_d    = tx_data_q;
    new_tx_d     = 1'b0;
    wait_first_d = 1'b0;
    case (state_q)
      COLLECT: begin
        if (last_char) state_d = LOAD;
`ifdef RX_ECHO_EN
        if (bus.new_rx_data && !bus.tx_busy) begin
          tx_data_d = bus.rx_data;
          new_tx_d  = 1'b1;
        end
`endif
      end
      LOAD: begin
        addr_d  = '0;
        state_d = READ;
      end
      READ: state_d = SEND;
      SEND: begin
        if (!bus.tx_busy) begin
          tx_data_d    = bus.rom_data;
          new_tx_d     = 1'b1;
          wait_first_d = 1'b1;
          state_d      = WAIT;
        end
      end
      WAIT: begin
        // The transmitter raises busy a cycle late, so the first WAIT cycle is blind.
        if (!wait_first_q && !bus.tx_busy) begin
          if (addr_q == ADDR_LAST) begin
            addr_d  = '0;
            state_d = COLLECT;
          end else begin
            addr_d  = addr_q + 1'b1;
            state_d = READ;
          end
        end
      end
      default: state_d = COLLECT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= COLLECT;
      addr_q       <= '0;
      tx_data_q    <= '0;
      new_tx_q     <= 1'b0;
      wait_first_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      tx_data_q    <= tx_data_d;
      new_tx_q     <= new_tx_d;
      wait_first_q <= wait_first_d;
    end
  end

  assign bus.addr        = addr_q;
  assign bus.tx_data     = tx_data_q;
  assign bus.new_tx_data = new_tx_q;
endmodule
